// File: rtl/lc_1512_pkg.sv
// lc_1512_pkg: shared FSM state type and default sizing for the pair counter
package lc_1512_pkg;
  typedef enum logic [1:0] {ACCUM, EMIT, CLEAR} state_t;
  localparam int DATA_SIZE_D = 32;
  localparam int VALUE_W_D = 7;
  localparam int CNT_W_D = 8;
endpackage

// File: rtl/lc_1512_count_mem.sv
// lc_1512_count_mem: per-value occurrence table, async read, sync write with clear port
module lc_1512_count_mem #(
  parameter int VALUE_W = 7,
  parameter int CNT_W = 8
) (
  input  logic               clk,
  input  logic [VALUE_W-1:0] addr,
  output logic [CNT_W-1:0]   rd_data,
  input  logic               we,
  input  logic [CNT_W-1:0]   wr_data,
  input  logic               clr,
  input  logic [VALUE_W-1:0] clr_addr
);
  logic [CNT_W-1:0] mem [2**VALUE_W];
  assign rd_data = mem[addr];
  // clearing has priority; it only happens while no elements are accepted
  always_ff @(posedge clk)
    if (clr) mem[clr_addr] <= '0;
    else if (we) mem[addr] <= wr_data;
endmodule

// File: rtl/lc_1512_pair_ctrl.sv
// lc_1512_pair_ctrl: counts equal-value pairs per frame, emits the count, then wipes the table
module lc_1512_pair_ctrl
  import lc_1512_pkg::*;
#(
  parameter int DATA_SIZE = DATA_SIZE_D,
  parameter int VALUE_W = VALUE_W_D,
  parameter int CNT_W = CNT_W_D
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DATA_SIZE-1:0] in_tdata,
  input  logic                 in_tvalid,
  input  logic                 in_tlast,
  output logic                 in_tready,
  output logic [DATA_SIZE-1:0] out_tdata,
  output logic                 out_tuser,
  output logic                 out_tvalid,
  input  logic                 out_tready
);
  state_t state, state_n;
  logic [VALUE_W-1:0] clr_addr;
  logic [DATA_SIZE-1:0] sum;
  logic err;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [DATA_SIZE:0] sum_x;
  logic acc, in_rng, wr;
  assign in_tready = state == ACCUM;
  assign acc = in_tvalid && in_tready;
  assign in_rng = (in_tdata >> VALUE_W) == '0;
  assign wr = acc && in_rng;
  assign cnt_n = &cnt ? cnt : cnt + 1'b1;
  assign sum_x = {1'b0, sum} + (DATA_SIZE + 1)'(cnt);
  assign out_tvalid = state == EMIT;
  assign out_tdata = sum;
  assign out_tuser = err;
  lc_1512_count_mem #(.VALUE_W(VALUE_W), .CNT_W(CNT_W)) u_mem (
    .clk(clk),
    .addr(in_tdata[VALUE_W-1:0]),
    .rd_data(cnt),
    .we(wr),
    .wr_data(cnt_n),
    .clr(state == CLEAR),
    .clr_addr(clr_addr)
  );
  // state register
  always_ff @(posedge clk)
    if (rst) state <= CLEAR;
    else state <= state_n;
  // next state: last accept -> EMIT, handshake -> CLEAR, final clear address -> ACCUM
  always_comb begin
    state_n = state;
    state_n = (acc && in_tlast) ? EMIT :
              (state == EMIT && out_tready) ? CLEAR :
              (state == CLEAR && &clr_addr) ? ACCUM : state;
  end
  // sum, error flag and clear sweep; the result is zeroed as it leaves EMIT
  always_ff @(posedge clk)
    if (rst) begin
      clr_addr <= '0;
      sum <= '0;
      err <= 1'b0;
    end else begin
      clr_addr <= state == CLEAR ? clr_addr + 1'b1 : '0;
      if (wr) sum <= sum_x[DATA_SIZE] ? '1 : sum_x[DATA_SIZE-1:0];
      if (acc && !in_rng) err <= 1'b1;
      if (state == EMIT && out_tready) begin
        sum <= '0;
        err <= 1'b0;
      end
    end
endmodule

// File: tb/tb_lc_1512_pair_ctrl.sv
// tb_lc_1512_pair_ctrl: directed and random frames checked against a pair-count model
module tb_lc_1512_pair_ctrl;
  logic clk = 0, rst = 1;
  logic [31:0] in_tdata = 0, out_tdata;
  logic in_tvalid = 0, in_tlast = 0, in_tready, out_tuser, out_tvalid, out_tready = 0;
  int tests = 0, fails = 0;

  lc_1512_pair_ctrl dut (
    .clk(clk), .rst(rst), .in_tdata(in_tdata), .in_tvalid(in_tvalid), .in_tlast(in_tlast),
    .in_tready(in_tready), .out_tdata(out_tdata), .out_tuser(out_tuser),
    .out_tvalid(out_tvalid), .out_tready(out_tready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input longint obs, input longint exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // k-th repeat of a value pairs with min(k, 255) earlier copies (counter saturates at 255)
  function automatic longint model(input int q[$], output bit e);
    int n[128];
    longint p = 0;
    e = 0;
    foreach (n[i]) n[i] = 0;
    foreach (q[i])
      if (q[i] >= 128) e = 1;
      else begin
        p += (n[q[i]] > 255) ? 255 : n[q[i]];
        n[q[i]]++;
      end
    return p;
  endfunction

  task automatic send(input int d, input bit last);
    int n = 0;
    in_tdata = d; in_tvalid = 1; in_tlast = last;
    while (!in_tready && n < 1000) begin n++; @(negedge clk); end
    if (n >= 1000) chk("send_timeout", n, 0);
    @(negedge clk);
    in_tvalid = 0; in_tlast = 0;
  endtask

  task automatic send_frame(input int q[$], input bit b2b);
    foreach (q[i]) begin
      if (!b2b) repeat ($urandom_range(0, 2)) begin
        in_tdata = $urandom; in_tvalid = 0;
        @(negedge clk);
      end
      send(q[i], i == q.size() - 1);
    end
  endtask

  task automatic recv(input string tag, input longint es, input bit ee, input int hold);
    int n = 0;
    logic [31:0] d0;
    while (!out_tvalid && n < 1000) begin n++; @(negedge clk); end
    chk({tag, "_valid"}, out_tvalid, 1);
    chk({tag, "_data"}, out_tdata, es);
    chk({tag, "_user"}, out_tuser, ee);
    d0 = out_tdata;
    repeat (hold) begin
      @(negedge clk);
      chk({tag, "_hold_valid"}, out_tvalid, 1);
      chk({tag, "_hold_data"}, out_tdata, d0);
      chk({tag, "_hold_rdy"}, in_tready, 0);
    end
    out_tready = 1;
    @(negedge clk);
    out_tready = 0;
    chk({tag, "_done"}, out_tvalid, 0);
  endtask

  task automatic frame(input string tag, input int q[$], input bit b2b, input int hold);
    bit e;
    longint p;
    p = model(q, e);
    send_frame(q, b2b);
    recv(tag, p, e, hold);
  endtask

  task automatic clear_len(input string tag);
    int n = 0;
    while (!in_tready && n < 1000) begin
      if (out_tvalid) chk({tag, "_spurious"}, out_tvalid, 0);
      n++;
      @(negedge clk);
    end
    chk(tag, n, 128);
  endtask

  initial begin
    int q[$];
    bit e;
    repeat (3) @(negedge clk);
    chk("rst_rdy", in_tready, 0);
    chk("rst_valid", out_tvalid, 0);
    chk("rst_data", out_tdata, 0);
    chk("rst_user", out_tuser, 0);
    rst = 0;
    clear_len("rst_clear_len");
    frame("f123113", '{1, 2, 3, 1, 1, 3}, 0, 0);
    frame("f1111", '{1, 1, 1, 1}, 1, 0);
    frame("f123", '{1, 2, 3}, 0, 0);
    clear_len("clear_len");
    frame("f55", '{5, 5}, 0, 0);
    frame("hold10", '{9, 9, 9}, 1, 10);
    frame("f7_200_7", '{7, 200, 7}, 0, 0);
    frame("f7", '{7}, 0, 0);
    send(4, 0);
    send(4, 0);
    rst = 1;
    @(negedge clk);
    rst = 0;
    clear_len("abort_clear_len");
    frame("after_abort", '{4}, 0, 0);
    q = {};
    repeat (300) q.push_back(17);
    chk("sat_model", model(q, e), 43860);
    frame("cnt_sat", q, 1, 0);
    frame("max_idx", '{127, 127, 128, 0, 0}, 1, 0);
    for (int f = 0; f < 25; f++) begin
      q = {};
      repeat ($urandom_range(1, 14))
        q.push_back(($urandom_range(0, 9) == 0) ? $urandom_range(128, 1000) : $urandom_range(0, 11));
      frame("rand", q, $urandom_range(0, 1), $urandom_range(0, 3));
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/lc_1512_pair_ctrl.md
LC_1512_PAIR_CTRL -- requirements
Module: lc_1512_pair_ctrl

Interface
REQ-001 Parameter DATA_SIZE, default 32: width of the input element and the result.
REQ-002 Parameter VALUE_W, default 7: index width of the count table, which has 2**VALUE_W entries.
REQ-003 Parameter CNT_W, default 8: width of each per-value occurrence counter.
REQ-004 Port clk, input, 1: the only clock; all logic is on its rising edge.
REQ-005 Port rst, input, 1: synchronous active-high reset.
REQ-006 Port in_tdata, input, DATA_SIZE: element value.
REQ-007 Port in_tvalid, input, 1: element valid.
REQ-008 Port in_tlast, input, 1: last element of the frame.
REQ-009 Port in_tready, output, 1: block accepts an element.
REQ-010 Port out_tdata, output, DATA_SIZE: good-pair count of the frame.
REQ-011 Port out_tuser, output, 1: frame contained at least one out-of-range element.
REQ-012 Port out_tvalid, output, 1: result valid.
REQ-013 Port out_tready, input, 1: downstream accepts the result.

Function
REQ-014 The block SHALL be a 3-state FSM: ACCUM, EMIT, CLEAR.
REQ-015 An element SHALL be accepted only in a cycle where in_tvalid=1 and in_tready=1; in_tready SHALL be 1 only in ACCUM.
REQ-016 On an accepted element with in_tdata < 2**VALUE_W, with v = in_tdata[VALUE_W-1:0]: the block SHALL add cnt[v] (pre-increment value) to the running pair sum and increment cnt[v] in the same cycle.
REQ-017 Back-to-back accepts of the same v SHALL use the already-updated count (no RMW hazard); one element per cycle is the sustained rate.
REQ-018 An accepted element with in_tdata >= 2**VALUE_W SHALL NOT touch the table or the sum, and SHALL set the frame error flag.
REQ-019 cnt[v] SHALL saturate at 2**CNT_W-1.
REQ-020 The pair sum SHALL saturate at 2**DATA_SIZE-1.
REQ-021 An accept with in_tlast=1 SHALL be processed per REQ-016 to REQ-018, and the FSM SHALL then go to EMIT on the next cycle.
REQ-022 In EMIT, out_tdata SHALL hold the final sum (including the last element) and out_tuser the error flag, with out_tvalid=1.
REQ-023 out_tdata, out_tuser and out_tvalid SHALL remain stable until out_tready=1.
REQ-024 In EMIT, the cycle with out_tready=1 completes the transfer; the FSM SHALL then go to CLEAR.
REQ-025 CLEAR SHALL zero one table entry per cycle, from address 0 up to 2**VALUE_W-1, taking exactly 2**VALUE_W cycles.
REQ-026 CLEAR SHALL then go to ACCUM with sum=0 and error flag=0.
REQ-027 A single-element frame SHALL yield 0.
REQ-028 in_tvalid=0 in ACCUM SHALL change no state.
REQ-029 out_tvalid SHALL be 0 outside EMIT.

Reset
REQ-030 Reset SHALL force state=CLEAR, clear address=0, sum=0, error flag=0, out_tvalid=0, out_tdata=0, out_tuser=0 and in_tready=0.
REQ-031 After reset deasserts, in_tready SHALL stay 0 for 2**VALUE_W cycles while the table is cleared.
REQ-032 Reset mid-frame or mid-EMIT SHALL discard the partial frame and any pending result.

Structure
REQ-033 Package lc_1512_pkg SHALL hold the FSM state enum and the default DATA_SIZE, VALUE_W and CNT_W constants.
REQ-034 Sub-module lc_1512_count_mem SHALL hold the count table, with a combinational read port, a synchronous write port and a clear-address write.
REQ-035 The FSM, sum and handshake logic SHALL be in lc_1512_pair_ctrl.

Verification
REQ-036 Frame [1,2,3,1,1,3] -> out_tdata=4, out_tuser=0.
REQ-037 Frame [1,1,1,1] sent back-to-back -> out_tdata=6.
REQ-038 Frame [1,2,3] -> 0; then in_tready=0 for exactly 128 cycles after the result handshake; then frame [5,5] -> 1.
REQ-039 out_tready held 0 for 10 cycles in EMIT -> out_tvalid=1 and out_tdata stable, in_tready=0 throughout.
REQ-040 Frame [7,200,7] -> out_tdata=1, out_tuser=1; the next frame [7] -> 0, out_tuser=0.
REQ-041 Reset asserted after accepting [4,4] mid-frame, then frame [4] -> 0, with no result output for the aborted frame.
